// File: rtl/conv_layer_cfg_loader_pkg.sv
// Shared FSM encoding and geometry helpers for the conv-layer config loader
// and the conv layer wrapper that sizes its shift registers from the same rules.
package conv_layer_cfg_loader_pkg;

  typedef logic [2:0] cfg_state_t;

  localparam cfg_state_t ST_IDLE      = 3'd0;
  localparam cfg_state_t ST_LOAD_W    = 3'd1;
  localparam cfg_state_t ST_COMMIT_W  = 3'd2;
  localparam cfg_state_t ST_LOAD_TH   = 3'd3;
  localparam cfg_state_t ST_COMMIT_TH = 3'd4;
  localparam cfg_state_t ST_DONE      = 3'd5;

  function automatic int calc_fold_log(input int fold);
    return (fold == 1) ? 1 : $clog2(fold);
  endfunction

  function automatic int calc_res_w(input int ch_in, input int k_s, input int maj);
    return (maj != 0) ? $clog2(ch_in * k_s) : $clog2(ch_in * k_s * k_s);
  endfunction

  function automatic int calc_w_bits(input int fold, input int ch_in, input int ch_out, input int k_s);
    return ch_in * k_s * k_s * ((fold == 1) ? 1 : ch_out / fold);
  endfunction

  function automatic int calc_th_bits(input int fold, input int ch_out, input int res_w);
    return res_w * ((fold == 1) ? 1 : ch_out / fold);
  endfunction

  // Chunk-length counters must hold the larger of the two chunk sizes.
  function automatic int calc_len_w(input int w_bits, input int th_bits);
    return $clog2(((w_bits > th_bits) ? w_bits : th_bits) + 1);
  endfunction

endpackage

// File: rtl/conv_layer_cfg_loader_cfg_word_serializer.sv
// Buffers one host word and emits it MSB-first, one bit per cycle, fetching
// only as many words as the current chunk needs and dropping unused low bits.
module conv_layer_cfg_loader_cfg_word_serializer #(
  parameter int BUS_W = 32,
  parameter int LEN_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             chunk_start,
  input  logic [LEN_W-1:0] chunk_len,
  input  logic             active,
  input  logic [BUS_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             shift_en,
  output logic             shift_bit,
  output logic             chunk_last
);

  localparam int CNT_W = $clog2(BUS_W + 1);

  logic [BUS_W-1:0] word_reg;
  logic [CNT_W-1:0] avail_reg;
  logic [LEN_W-1:0] fetch_left_reg;
  logic [31:0]      fetch_left_ext;
  logic [CNT_W-1:0] take;
  logic             have_bits;
  logic             hs;

  assign fetch_left_ext = 32'(fetch_left_reg);
  assign take           = (fetch_left_ext >= 32'(BUS_W)) ? CNT_W'(BUS_W) : CNT_W'(fetch_left_reg);
  assign have_bits      = (avail_reg != '0);

  // A new word may land in the same cycle the last buffered bit leaves, so words stream gap-free.
  assign in_ready   = active && (fetch_left_reg != '0) && (avail_reg <= CNT_W'(1));
  assign hs         = in_ready && in_valid;
  assign shift_en   = active && (have_bits || hs);
  assign shift_bit  = have_bits ? word_reg[BUS_W-1] : in_data[BUS_W-1];
  assign chunk_last = shift_en && (have_bits ? ((avail_reg == CNT_W'(1)) && (fetch_left_reg == '0))
                                             : (fetch_left_reg == LEN_W'(1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_reg       <= '0;
      avail_reg      <= '0;
      fetch_left_reg <= '0;
    end else if (flush) begin
      word_reg       <= '0;
      avail_reg      <= '0;
      fetch_left_reg <= '0;
    end else if (chunk_start) begin
      word_reg       <= '0;
      avail_reg      <= '0;
      fetch_left_reg <= chunk_len;
    end else if (active) begin
      if (hs) begin
        fetch_left_reg <= fetch_left_reg - LEN_W'(take);
        if (have_bits) begin
          word_reg  <= in_data;
          avail_reg <= take;
        end else begin
          word_reg  <= in_data << 1;
          avail_reg <= take - CNT_W'(1);
        end
      end else if (have_bits) begin
        word_reg  <= word_reg << 1;
        avail_reg <= avail_reg - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/conv_layer_cfg_loader.sv
// Sequences per-fold weight then threshold bit-serial loads into a conv layer,
// pulsing the matching commit enable after each chunk and reporting done.
module conv_layer_cfg_loader
  import conv_layer_cfg_loader_pkg::*;
#(
  parameter int FOLD            = 1,
  parameter int CH_IN           = 64,
  parameter int CH_OUT          = 64,
  parameter int K_S             = 3,
  parameter int MAJORITY_ENABLE = 0,
  parameter int BUS_W           = 32,
  localparam int FOLD_LOG       = calc_fold_log(FOLD)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_start,
  input  logic                cfg_abort,
  input  logic [BUS_W-1:0]    in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                stream_w_singlebit,
  output logic                stream_w_singlebit_en,
  output logic                stream_w_en,
  output logic [FOLD_LOG-1:0] stream_w_addr,
  output logic                stream_th_singlebit,
  output logic                stream_th_singlebit_en,
  output logic                stream_th_en,
  output logic [FOLD_LOG-1:0] stream_th_addr,
  output logic                cfg_busy,
  output logic                cfg_done
);

  localparam int RES_W   = calc_res_w(CH_IN, K_S, MAJORITY_ENABLE);
  localparam int W_BITS  = calc_w_bits(FOLD, CH_IN, CH_OUT, K_S);
  localparam int TH_BITS = calc_th_bits(FOLD, CH_OUT, RES_W);
  localparam int LEN_W   = calc_len_w(W_BITS, TH_BITS);

  cfg_state_t          state_reg, state_next;
  logic [FOLD_LOG-1:0] fold_reg, fold_next;
  logic                chunk_start;
  logic [LEN_W-1:0]    chunk_len;
  logic                commit_w, commit_th, done_pulse;
  logic                is_load_w, is_load_th, ser_active;
  logic                shift_en, shift_bit, chunk_last;

  assign is_load_w  = (state_reg == ST_LOAD_W);
  assign is_load_th = (state_reg == ST_LOAD_TH);
  assign ser_active = (is_load_w || is_load_th) && !cfg_abort;

  conv_layer_cfg_loader_cfg_word_serializer #(
    .BUS_W(BUS_W),
    .LEN_W(LEN_W)
  ) u_serializer (
    .clk        (clk),
    .reset      (reset),
    .flush      (cfg_abort),
    .chunk_start(chunk_start),
    .chunk_len  (chunk_len),
    .active     (ser_active),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .shift_en   (shift_en),
    .shift_bit  (shift_bit),
    .chunk_last (chunk_last)
  );

  always_comb begin
    state_next  = state_reg;
    fold_next   = fold_reg;
    chunk_start = 1'b0;
    chunk_len   = '0;
    commit_w    = 1'b0;
    commit_th   = 1'b0;
    done_pulse  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cfg_start) begin
          state_next  = ST_LOAD_W;
          fold_next   = '0;
          chunk_start = 1'b1;
          chunk_len   = LEN_W'(W_BITS);
        end
      end
      ST_LOAD_W: begin
        if (chunk_last) state_next = ST_COMMIT_W;
      end
      ST_COMMIT_W: begin
        commit_w    = 1'b1;
        state_next  = ST_LOAD_TH;
        chunk_start = 1'b1;
        chunk_len   = LEN_W'(TH_BITS);
      end
      ST_LOAD_TH: begin
        if (chunk_last) state_next = ST_COMMIT_TH;
      end
      ST_COMMIT_TH: begin
        commit_th = 1'b1;
        if (fold_reg == FOLD_LOG'(FOLD - 1)) begin
          state_next = ST_DONE;
        end else begin
          fold_next   = fold_reg + FOLD_LOG'(1);
          state_next  = ST_LOAD_W;
          chunk_start = 1'b1;
          chunk_len   = LEN_W'(W_BITS);
        end
      end
      ST_DONE: begin
        done_pulse = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Abort outranks everything, including a start in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg              <= ST_IDLE;
      fold_reg               <= '0;
      stream_w_singlebit     <= 1'b0;
      stream_w_singlebit_en  <= 1'b0;
      stream_w_en            <= 1'b0;
      stream_w_addr          <= '0;
      stream_th_singlebit    <= 1'b0;
      stream_th_singlebit_en <= 1'b0;
      stream_th_en           <= 1'b0;
      stream_th_addr         <= '0;
      cfg_busy               <= 1'b0;
      cfg_done               <= 1'b0;
    end else if (cfg_abort) begin
      state_reg              <= ST_IDLE;
      fold_reg               <= '0;
      stream_w_singlebit     <= 1'b0;
      stream_w_singlebit_en  <= 1'b0;
      stream_w_en            <= 1'b0;
      stream_w_addr          <= '0;
      stream_th_singlebit    <= 1'b0;
      stream_th_singlebit_en <= 1'b0;
      stream_th_en           <= 1'b0;
      stream_th_addr         <= '0;
      cfg_busy               <= 1'b0;
      cfg_done               <= 1'b0;
    end else begin
      state_reg              <= state_next;
      fold_reg               <= fold_next;
      stream_w_singlebit     <= shift_en && is_load_w && shift_bit;
      stream_w_singlebit_en  <= shift_en && is_load_w;
      stream_th_singlebit    <= shift_en && is_load_th && shift_bit;
      stream_th_singlebit_en <= shift_en && is_load_th;
      stream_w_en            <= commit_w;
      stream_th_en           <= commit_th;
      if (commit_w)  stream_w_addr  <= fold_reg;
      if (commit_th) stream_th_addr <= fold_reg;
      cfg_done <= done_pulse;
      if (state_reg == ST_IDLE && cfg_start) cfg_busy <= 1'b1;
      else if (done_pulse)                   cfg_busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_layer_cfg_loader.sv
// Randomized-word bench for the config loader: a small FOLD=2 instance for the
// protocol scenarios and a default-parameter instance for the full-size load.
module tb_conv_layer_cfg_loader;

  localparam int BW       = 8;
  localparam int W1       = 4 * 3 * 3 * (4 / 2);
  localparam int TH1      = $clog2(4 * 3 * 3) * (4 / 2);
  localparam int WW       = (W1 + BW - 1) / BW;
  localparam int WT       = (TH1 + BW - 1) / BW;
  localparam int WPF      = WW + WT;
  // Each fold costs its bits plus two commit cycles; one more cycle for done.
  localparam int LOAD_CYC = 2 * (W1 + TH1 + 2) + 1;
  localparam int W2       = 64 * 3 * 3;
  localparam int TH2      = $clog2(64 * 3 * 3);
  localparam int WW2      = (W2 + 31) / 32;
  localparam int LOAD2    = W2 + TH2 + 3;
  localparam int LIMIT    = 3000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cfg_start = 1'b0, cfg_abort = 1'b0;
  logic [BW-1:0] in_data = '0;
  logic in_valid = 1'b0, in_ready;
  logic w_bit, w_bit_en, w_en, th_bit, th_bit_en, th_en, busy, done;
  logic [0:0] w_addr, th_addr;

  logic cfg_start2 = 1'b0;
  logic [31:0] in_data2 = '0;
  logic in_valid2 = 1'b0, in_ready2;
  logic w_bit2, w_bit_en2, w_en2, th_bit2, th_bit_en2, th_en2, busy2, done2;
  logic [0:0] w_addr2, th_addr2;

  always #5 clk = ~clk;

  conv_layer_cfg_loader #(.FOLD(2), .CH_IN(4), .CH_OUT(4), .K_S(3), .MAJORITY_ENABLE(0), .BUS_W(BW)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .stream_w_singlebit(w_bit), .stream_w_singlebit_en(w_bit_en), .stream_w_en(w_en), .stream_w_addr(w_addr),
    .stream_th_singlebit(th_bit), .stream_th_singlebit_en(th_bit_en), .stream_th_en(th_en), .stream_th_addr(th_addr),
    .cfg_busy(busy), .cfg_done(done)
  );

  conv_layer_cfg_loader dut2 (
    .clk(clk), .reset(reset), .cfg_start(cfg_start2), .cfg_abort(1'b0),
    .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .stream_w_singlebit(w_bit2), .stream_w_singlebit_en(w_bit_en2), .stream_w_en(w_en2), .stream_w_addr(w_addr2),
    .stream_th_singlebit(th_bit2), .stream_th_singlebit_en(th_bit_en2), .stream_th_en(th_en2), .stream_th_addr(th_addr2),
    .cfg_busy(busy2), .cfg_done(done2)
  );

  logic [BW-1:0] word_mem [0:63];
  logic [31:0]   word2_mem [0:31];
  int  hs_cnt = 0, hs_base = 0, gap_pct = 0, hs2 = 0;
  bit  host_on = 1'b0, host2_on = 1'b0, took = 1'b0;

  // Host model: holds a presented word until it is taken, random gaps otherwise.
  always begin
    @(negedge clk);
    if (!host_on) in_valid = 1'b0;
    else if (!in_valid || took) in_valid = ($urandom_range(99) >= gap_pct);
    in_data = word_mem[(hs_cnt - hs_base) % 64];
    took = 1'b0;
    #4;
    if (in_valid && in_ready) begin
      hs_cnt++;
      took = 1'b1;
    end
  end

  always begin
    @(negedge clk);
    in_valid2 = host2_on;
    in_data2 = word2_mem[hs2 % 32];
    #4;
    if (in_valid2 && in_ready2) hs2++;
  end

  bit obs_w[$], obs_th[$], obs_w2[$], obs_th2[$];
  int w_commit_addr[$], w_commit_pos[$], th_commit_addr[$], th_commit_pos[$];
  int done_cnt = 0, w2_commits = 0, th2_commits = 0, c2_bad_addr = 0;

  always @(negedge clk) begin
    if (w_bit_en)  obs_w.push_back(w_bit);
    if (th_bit_en) obs_th.push_back(th_bit);
    if (w_en)  begin w_commit_addr.push_back(int'(w_addr));  w_commit_pos.push_back(obs_w.size());  end
    if (th_en) begin th_commit_addr.push_back(int'(th_addr)); th_commit_pos.push_back(obs_th.size()); end
    if (done) done_cnt++;
    if (w_bit_en2)  obs_w2.push_back(w_bit2);
    if (th_bit_en2) obs_th2.push_back(th_bit2);
    if (w_en2)  begin w2_commits++;  if (w_addr2 != 1'b0)  c2_bad_addr++; end
    if (th_en2) begin th2_commits++; if (th_addr2 != 1'b0) c2_bad_addr++; end
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [15:0] outs1();
    return {in_ready, w_bit, w_bit_en, w_en, w_addr, th_bit, th_bit_en, th_en, th_addr, busy, done};
  endfunction

  task automatic obs_clear();
    obs_w.delete(); obs_th.delete();
    w_commit_addr.delete(); w_commit_pos.delete();
    th_commit_addr.delete(); th_commit_pos.delete();
    done_cnt = 0;
  endtask

  task automatic run_load(input string tag, input int hold, output int cyc);
    obs_clear();
    hs_base = hs_cnt;
    host_on = 1'b1;
    tick();
    cfg_start = 1'b1;
    cyc = LIMIT;
    for (int c = 0; c < LIMIT; c++) begin
      tick();
      if (c == 0) chk({tag, "_busy_after_start"}, busy, 1);
      if (c >= hold) cfg_start = 1'b0;
      if (done) begin
        cyc = c;
        break;
      end
    end
    cfg_start = 1'b0;
    host_on = 1'b0;
    tick();
    chk({tag, "_busy_after_done"}, busy, 0);
  endtask

  task automatic check_full_load(input string tag);
    int wm, tm;
    logic [BW-1:0] wd;
    wm = 0;
    tm = 0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < W1; i++) begin
        wd = word_mem[f * WPF + i / BW];
        if (f * W1 + i >= obs_w.size()) wm++;
        else if (obs_w[f * W1 + i] !== wd[BW - 1 - i % BW]) wm++;
      end
      for (int i = 0; i < TH1; i++) begin
        wd = word_mem[f * WPF + WW + i / BW];
        if (f * TH1 + i >= obs_th.size()) tm++;
        else if (obs_th[f * TH1 + i] !== wd[BW - 1 - i % BW]) tm++;
      end
    end
    chk({tag, "_w_bit_count"}, obs_w.size(), 2 * W1);
    chk({tag, "_th_bit_count"}, obs_th.size(), 2 * TH1);
    chk({tag, "_w_bit_errors"}, wm, 0);
    chk({tag, "_th_bit_errors"}, tm, 0);
    chk({tag, "_w_commits"}, w_commit_addr.size(), 2);
    chk({tag, "_th_commits"}, th_commit_addr.size(), 2);
    if (w_commit_addr.size() == 2 && th_commit_addr.size() == 2) begin
      chk({tag, "_w_commit_addrs"}, {w_commit_addr[0], w_commit_addr[1]}, {32'd0, 32'd1});
      chk({tag, "_w_commit_pos"}, {w_commit_pos[0], w_commit_pos[1]}, {W1, 2 * W1});
      chk({tag, "_th_commit_addrs"}, {th_commit_addr[0], th_commit_addr[1]}, {32'd0, 32'd1});
      chk({tag, "_th_commit_pos"}, {th_commit_pos[0], th_commit_pos[1]}, {TH1, 2 * TH1});
    end
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_handshakes"}, hs_cnt - hs_base, 2 * WPF);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, n, wm, tm;
    for (int i = 0; i < 64; i++) word_mem[i] = BW'($urandom);
    for (int i = 0; i < 32; i++) word2_mem[i] = $urandom;

    repeat (3) tick();
    chk("reset_outs", outs1(), 0);
    chk("reset_outs2", {in_ready2, w_bit_en2, w_en2, th_bit_en2, th_en2, busy2, done2}, 0);
    reset = 1'b1;
    tick();
    chk("idle_outs", outs1(), 0);

    // 1: back-to-back words
    gap_pct = 0;
    run_load("t1", 0, cyc);
    chk("t1_start_to_done", cyc, LOAD_CYC);
    check_full_load("t1");

    // 2: random host gaps, same words
    gap_pct = 30;
    run_load("t2", 0, cyc);
    chk("t2_not_faster", cyc >= LOAD_CYC, 1);
    check_full_load("t2");

    // 3: abort at fold 1 weight bit 40, then a clean load
    gap_pct = 0;
    obs_clear();
    hs_base = hs_cnt;
    host_on = 1'b1;
    tick();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    n = 0;
    while (obs_w.size() < W1 + 41 && n < LIMIT) begin
      tick();
      n++;
    end
    chk("t3_reached_bit40", obs_w.size(), W1 + 41);
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    host_on = 1'b0;
    chk("t3_outs_after_abort", outs1(), 0);
    repeat (40) tick();
    chk("t3_w_commits", w_commit_addr.size(), 1);
    chk("t3_th_commits", th_commit_addr.size(), 1);
    chk("t3_no_done", done_cnt, 0);
    chk("t3_idle_outs", outs1(), 0);
    for (int i = 0; i < 64; i++) word_mem[i] = BW'($urandom);
    run_load("t3b", 0, cyc);
    chk("t3b_start_to_done", cyc, LOAD_CYC);
    check_full_load("t3b");

    // 4: start held through much of a load; start+abort together in idle
    run_load("t4", 50, cyc);
    chk("t4_start_to_done", cyc, LOAD_CYC);
    check_full_load("t4");
    obs_clear();
    cfg_start = 1'b1;
    cfg_abort = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    chk("t4_start_abort_outs", outs1(), 0);
    repeat (5) tick();
    chk("t4_start_abort_still_idle", {outs1(), 16'(obs_w.size())}, 0);

    // 5: async reset at fold 0 threshold bit 5
    obs_clear();
    hs_base = hs_cnt;
    host_on = 1'b1;
    tick();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    n = 0;
    while (obs_th.size() < 6 && n < LIMIT) begin
      tick();
      n++;
    end
    chk("t5_reached_th_bit5", obs_th.size(), 6);
    #1 reset = 1'b0;
    #1 chk("t5_async_reset_outs", outs1(), 0);
    host_on = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    run_load("t5b", 0, cyc);
    chk("t5b_start_to_done", cyc, LOAD_CYC);
    check_full_load("t5b");

    // 6: default parameters, 32-bit bus
    obs_w2.delete();
    obs_th2.delete();
    hs2 = 0;
    host2_on = 1'b1;
    tick();
    cfg_start2 = 1'b1;
    cyc = LIMIT;
    for (int c = 0; c < LIMIT; c++) begin
      tick();
      cfg_start2 = 1'b0;
      if (done2) begin
        cyc = c;
        break;
      end
    end
    host2_on = 1'b0;
    tick();
    wm = 0;
    tm = 0;
    for (int i = 0; i < W2; i++)
      if (i >= obs_w2.size() || obs_w2[i] !== word2_mem[i / 32][31 - i % 32]) wm++;
    for (int i = 0; i < TH2; i++)
      if (i >= obs_th2.size() || obs_th2[i] !== word2_mem[WW2][31 - i]) tm++;
    chk("t6_start_to_done", cyc, LOAD2);
    chk("t6_w_bit_count", obs_w2.size(), W2);
    chk("t6_th_bit_count", obs_th2.size(), TH2);
    chk("t6_w_bit_errors", wm, 0);
    chk("t6_th_bit_errors", tm, 0);
    chk("t6_commits", {w2_commits, th2_commits, c2_bad_addr}, {32'd1, 32'd1, 32'd0});
    chk("t6_handshakes", hs2, WW2 + 1);
    chk("t6_busy_after_done", busy2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
